// File: rtl/nano_mem_pkg.sv
// Shared types and constants for the nano-cpu memory port logic.
package nano_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;
    localparam int   WORD_BYTES = 4;

    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and byte-memory signals of the shared memory port.
interface mem_port_arbiter_if #(parameter int ADDR_W = 16);
    logic              f_req_valid;
    logic              f_req_ready;
    logic [31:0]       f_req_addr;
    logic              f_rsp_valid;
    logic [31:0]       f_rsp_rdata;
    logic              d_req_valid;
    logic              d_req_ready;
    logic [31:0]       d_req_addr;
    logic              d_req_we;
    logic [31:0]       d_req_wdata;
    logic              d_rsp_valid;
    logic [31:0]       d_rsp_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport slave (
        input  f_req_valid, f_req_addr, d_req_valid, d_req_addr, d_req_we, d_req_wdata, mem_rdata,
        output f_req_ready, f_rsp_valid, f_rsp_rdata, d_req_ready, d_rsp_valid, d_rsp_rdata,
               mem_addr, mem_we, mem_wdata
    );

    modport master (
        output f_req_valid, f_req_addr, d_req_valid, d_req_addr, d_req_we, d_req_wdata, mem_rdata,
        input  f_req_ready, f_rsp_valid, f_rsp_rdata, d_req_ready, d_rsp_valid, d_rsp_rdata,
               mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/arb2_rr.sv
// Two-requester round-robin arbiter; bit 0 is the fetch port, bit 1 the data port.
module arb2_rr
    import nano_mem_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);
   logic last_q;

   // Grant selection; a tie goes to the port not granted last.
   always_comb begin
      gnt_o = 2'b00;
      if (en_i) begin
         case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_q == PORT_FETCH) ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
         endcase
      end else begin
         gnt_o = 2'b00;
      end
   end

   // Remember the most recent winner.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= PORT_FETCH;
      end else if (gnt_o != 2'b00) begin
         last_q <= gnt_o[1];
      end else begin
         last_q <= last_q;
      end
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// Sequences word requests from the fetch and data ports into four byte beats on the shared memory.
module mem_port_arbiter
    import nano_mem_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input logic              clk,
   input logic              rst,
   mem_port_arbiter_if.slave bus
);
   state_e            state_q, state_d;
   logic [1:0]        beat_q, beat_d;
   logic              port_q, port_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       data_q, data_d;
   logic [1:0]        gnt_s;
   logic              arb_en_s;
   logic              unused_s;

   assign unused_s = ^{bus.f_req_addr[31:ADDR_W], bus.d_req_addr[31:ADDR_W]};
   assign arb_en_s = (state_q == IDLE);

   arb2_rr u_arb (
      .clk   (clk),
      .rst   (rst),
      .en_i  (arb_en_s),
      .req_i ({bus.d_req_valid, bus.f_req_valid}),
      .gnt_o (gnt_s)
   );

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         beat_q  <= 2'd0;
         port_q  <= PORT_FETCH;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= 32'h0;
         data_q  <= 32'h0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         port_q  <= port_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         data_q  <= data_d;
      end
   end

   // Next-state logic. Load bytes shift in from the top so byte 0 lands in bits 7:0 after four captures.
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      port_d  = port_q;
      addr_d  = addr_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      data_d  = data_q;
      case (state_q)
         IDLE: begin
            if (gnt_s[1]) begin
               port_d  = PORT_DATA;
               addr_d  = bus.d_req_addr[ADDR_W-1:0];
               we_d    = bus.d_req_we;
               wdata_d = bus.d_req_wdata;
               beat_d  = 2'd0;
               data_d  = 32'h0;
               state_d = XFER;
            end else if (gnt_s[0]) begin
               port_d  = PORT_FETCH;
               addr_d  = bus.f_req_addr[ADDR_W-1:0];
               we_d    = 1'b0;
               wdata_d = 32'h0;
               beat_d  = 2'd0;
               data_d  = 32'h0;
               state_d = XFER;
            end else begin
               state_d = IDLE;
            end
         end
         XFER: begin
            if (!we_q && (beat_q != 2'd0)) begin
               data_d = {bus.mem_rdata, data_q[31:8]};
            end else begin
               data_d = data_q;
            end
            if (beat_q == 2'(WORD_BYTES - 1)) begin
               beat_d  = 2'd0;
               state_d = WAIT;
            end else begin
               beat_d  = beat_q + 2'd1;
            end
         end
         WAIT: begin
            if (!we_q) begin
               data_d = {bus.mem_rdata, data_q[31:8]};
            end else begin
               data_d = data_q;
            end
            state_d = RESP;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output decode from registered state; everything idles to zero.
   always_comb begin
      bus.f_req_ready = gnt_s[0];
      bus.d_req_ready = gnt_s[1];
      bus.mem_addr    = '0;
      bus.mem_we      = 1'b0;
      bus.mem_wdata   = 8'h00;
      bus.f_rsp_valid = 1'b0;
      bus.f_rsp_rdata = 32'h0;
      bus.d_rsp_valid = 1'b0;
      bus.d_rsp_rdata = 32'h0;
      if (state_q == XFER) begin
         bus.mem_addr  = addr_q + ADDR_W'(beat_q);
         bus.mem_we    = we_q;
         bus.mem_wdata = we_q ? byte_lane(wdata_q, beat_q) : 8'h00;
      end else if (state_q == RESP) begin
         if (port_q == PORT_DATA) begin
            bus.d_rsp_valid = 1'b1;
            bus.d_rsp_rdata = we_q ? 32'h0 : data_q;
         end else begin
            bus.f_rsp_valid = 1'b1;
            bus.f_rsp_rdata = data_q;
         end
      end else begin
         bus.mem_we = 1'b0;
      end
   end
endmodule
